// File: rtl/reservoir_input_sequencer_if.sv
// Sample/mask/reservoir signal bundle; master = the sequencer, slave = source and reservoir side.
interface reservoir_input_sequencer_if #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 16,
  parameter int ADDR_WIDTH        = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1
);
  logic                    s_valid;
  logic [SAMPLE_WIDTH-1:0] s_data;
  logic                    s_ready;
  logic                    mask_we;
  logic [ADDR_WIDTH-1:0]   mask_addr;
  logic [MASK_WIDTH-1:0]   mask_data;
  logic                    res_en;
  logic [DATA_WIDTH-1:0]   res_din;
  logic                    res_valid;
  logic [ADDR_WIDTH-1:0]   node_idx;
  logic                    busy;
  logic                    sample_done;
  logic                    timeout_err;

  modport master (
    input  s_valid, s_data, mask_we, mask_addr, mask_data, res_valid,
    output s_ready, res_en, res_din, node_idx, busy, sample_done, timeout_err
  );

  modport slave (
    output s_valid, s_data, mask_we, mask_addr, mask_data, res_valid,
    input  s_ready, res_en, res_din, node_idx, busy, sample_done, timeout_err
  );
endinterface

// File: rtl/reservoir_input_sequencer.sv
// Masks one sample per virtual node and injects each value into the reservoir via en/valid; one node per valid low-high round trip.
// Source stalled (s_ready=0) while busy; RESERVOIR_SEQ_TIMEOUT_EN adds a wait-state watchdog with sticky timeout_err.
module reservoir_input_sequencer #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int MASK_WIDTH        = 16,
  parameter int MASK_FRAC_BITS    = 8,
  parameter int DIN_SAT_BITS      = 15,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input logic clk,
  input logic rst,
  reservoir_input_sequencer_if.master bus
);
  localparam int AW = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
  localparam int PW = SAMPLE_WIDTH + MASK_WIDTH;
  localparam logic [PW-1:0] SAT_MAX = PW'((64'd1 << DIN_SAT_BITS) - 64'd1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [MASK_WIDTH-1:0]   mask_q [NUM_VIRTUAL_NODES];
  logic [AW-1:0]           node_q;
  logic                    s_ready_q, busy_q, res_en_q, done_q;
  logic [DATA_WIDTH-1:0]   res_din_q;
  logic                    last_node, accept, inject, timeout_hit;
  logic [PW-1:0]           prod, quot;
  logic [DATA_WIDTH-1:0]   din_nxt;

  assign last_node = (node_q == AW'(NUM_VIRTUAL_NODES - 1));
  assign accept    = (state == IDLE) && bus.s_valid && s_ready_q;
  assign inject    = (state == ISSUE) && bus.res_valid;

  assign prod    = PW'(sample_q) * PW'(mask_q[node_q]);
  assign quot    = prod >> MASK_FRAC_BITS;
  assign din_nxt = DATA_WIDTH'((quot > SAT_MAX) ? SAT_MAX : quot);

`ifdef RESERVOIR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_err_q;
  logic          in_wait, stay_wait;

  assign in_wait     = (state == WAIT_LOW) || (state == WAIT_HIGH);
  // Watchdog only fires on a cycle that would otherwise keep us waiting.
  assign stay_wait   = ((state == WAIT_LOW) && bus.res_valid) ||
                       ((state == WAIT_HIGH) && !bus.res_valid);
  assign timeout_hit = stay_wait && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state_nxt != state)
        wd_cnt <= '0;
      else if (in_wait)
        wd_cnt <= wd_cnt + TW'(1);
      if (timeout_hit)
        wd_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = wd_err_q;
`else
  // Watchdog compiled out: never fires, sequencer waits indefinitely.
  assign timeout_hit     = (TIMEOUT_CYCLES < 0);
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = ISSUE;
      ISSUE:     if (bus.res_valid) state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!bus.res_valid) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (bus.res_valid) state_nxt = last_node ? DONE : ISSUE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout_hit)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sample_q  <= '0;
      node_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      res_en_q  <= 1'b0;
      done_q    <= 1'b0;
      res_din_q <= '0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= (state_nxt == IDLE);
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);
      res_en_q  <= inject;
      if (accept) begin
        sample_q <= bus.s_data;
        node_q   <= '0;
      end
      // res_din only changes at an injection; the reservoir reads it throughout its busy time.
      if (inject)
        res_din_q <= din_nxt;
      if ((state == WAIT_HIGH) && bus.res_valid && !last_node)
        node_q <= node_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++)
        mask_q[i] <= '0;
    end else if ((state == IDLE) && bus.mask_we &&
                 (int'(bus.mask_addr) < NUM_VIRTUAL_NODES)) begin
      mask_q[bus.mask_addr] <= bus.mask_data;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.busy        = busy_q;
  assign bus.res_en      = res_en_q;
  assign bus.res_din     = res_din_q;
  assign bus.node_idx    = node_q;
  assign bus.sample_done = done_q;
endmodule
